// File: rtl/wb_rsp_fifo.sv
// Elastic buffer between the Wishbone master's response channel and the UART
// response coder; words are re-issued as single-cycle strobes gated by busy.
module wb_rsp_fifo #(
    parameter int DW      = 34,
    parameter int LGDEPTH = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr_stb,
    input  logic [DW-1:0]      i_wr_word,
    output logic               o_full,
    output logic               o_empty,
    output logic [LGDEPTH:0]   o_count,
    output logic               o_overflow,
    output logic               o_rd_stb,
    output logic [DW-1:0]      o_rd_word,
    input  logic               i_rd_busy
);

    localparam int DEPTH = 2 ** LGDEPTH;
    localparam logic [LGDEPTH:0] COUNT_FULL = (LGDEPTH+1)'(DEPTH);

    logic [DW-1:0]      mem [DEPTH];
    logic [LGDEPTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [LGDEPTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LGDEPTH:0]   count_reg, count_next;
    logic               overflow_reg, overflow_next;
    logic               rd_stb_reg, rd_stb_next;
    logic [DW-1:0]      rd_word_reg, rd_word_next;
    logic               full;
    logic               wr_accept;
    logic               pop;

    assign full = (count_reg == COUNT_FULL);

    // Full is judged on the registered count, so a simultaneous pop never
    // makes room for a write in the same cycle.
    assign wr_accept = i_wr_stb && !full;

    // The strobe itself blocks the next pop: the coder only raises busy one
    // cycle after it sees a strobe, which forces a one-cycle gap.
    assign pop = (count_reg != '0) && !i_rd_busy && !rd_stb_reg;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        rd_stb_next   = 1'b0;
        rd_word_next  = rd_word_reg;

        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (i_wr_stb && full) begin
            overflow_next = 1'b1;
        end
        if (pop) begin
            rd_ptr_next  = rd_ptr_reg + 1'b1;
            rd_stb_next  = 1'b1;
            rd_word_next = mem[rd_ptr_reg];
        end

        case ({wr_accept, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= i_wr_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            rd_stb_reg   <= 1'b0;
            rd_word_reg  <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            rd_stb_reg   <= rd_stb_next;
            rd_word_reg  <= rd_word_next;
        end
    end

    assign o_full     = full;
    assign o_empty    = (count_reg == '0);
    assign o_count    = count_reg;
    assign o_overflow = overflow_reg;
    assign o_rd_stb   = rd_stb_reg;
    assign o_rd_word  = rd_word_reg;

endmodule

// File: tb/tb_wb_rsp_fifo.sv
// Directed scoreboard bench for wb_rsp_fifo: accepted writes are queued as
// expectations and checked against every output strobe in order.
module tb_wb_rsp_fifo;

    localparam int DW      = 34;
    localparam int LGDEPTH = 3;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_wr_stb = 1'b0;
    logic [DW-1:0]      i_wr_word = '0;
    logic               o_full;
    logic               o_empty;
    logic [LGDEPTH:0]   o_count;
    logic               o_overflow;
    logic               o_rd_stb;
    logic [DW-1:0]      o_rd_word;
    logic               i_rd_busy;

    logic               busy_manual = 1'b0;
    logic               model_en = 1'b0;
    logic               model_busy = 1'b0;
    int                 model_cnt = 0;

    int                 n_cmp = 0;
    int                 n_err = 0;
    logic [DW-1:0]      exp_q [$];
    int                 cyc = 0;
    int                 last_stb_cyc = 0;
    logic               have_last = 1'b0;
    logic               spacing_en = 1'b0;
    int                 peak = 0;

    assign i_rd_busy = model_en ? model_busy : busy_manual;

    wb_rsp_fifo #(.DW(DW), .LGDEPTH(LGDEPTH)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_stb   (i_wr_stb),
        .i_wr_word  (i_wr_word),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_rd_stb   (o_rd_stb),
        .o_rd_word  (o_rd_word),
        .i_rd_busy  (i_rd_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor, coder busy model and fill-level peak tracker.
    always @(negedge i_clk) begin
        if (int'(o_count) > peak) peak = int'(o_count);
        if (o_rd_stb) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, o_rd_word}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("rd_word", {30'd0, o_rd_word}, {30'd0, exp_q.pop_front()});
            end
            if (spacing_en && have_last) begin
                check("strobe_spacing", 64'(cyc - last_stb_cyc), 64'd2);
            end
            last_stb_cyc = cyc;
            have_last = 1'b1;
            $display("rd strobe word=%09h count=%0d", o_rd_word, o_count);
        end
        // Coder raises busy the cycle after a strobe and holds it briefly.
        if (o_rd_stb) model_cnt = 4;
        else if (model_cnt > 0) model_cnt = model_cnt - 1;
        model_busy = (model_cnt > 0);
    end

    task automatic wr(input logic [DW-1:0] w, input bit push);
        i_wr_stb = 1'b1;
        i_wr_word = w;
        if (push) exp_q.push_back(w);
        $display("wr word=%09h expect_out=%0d", w, push);
        @(negedge i_clk);
        i_wr_stb = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        exp_q.delete();
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || o_rd_stb) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Test: reset state
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_empty", 64'(o_empty), 64'd1);
        check("rst_full", 64'(o_full), 64'd0);
        check("rst_overflow", 64'(o_overflow), 64'd0);
        check("rst_rd_stb", 64'(o_rd_stb), 64'd0);
        check("rst_rd_word", {30'd0, o_rd_word}, 64'd0);

        // Test: single write, one-cycle latency
        wr(34'h2_DEADBEEF, 1'b1);
        check("lat_stb_early", 64'(o_rd_stb), 64'd0);
        check("lat_count1", 64'(o_count), 64'd1);
        @(negedge i_clk);
        check("lat_stb", 64'(o_rd_stb), 64'd1);
        check("lat_count0", 64'(o_count), 64'd0);
        check("lat_empty", 64'(o_empty), 64'd1);
        @(negedge i_clk);
        check("single_drain", 64'(exp_q.size()), 64'd0);

        // Test: fill to full while busy
        busy_manual = 1'b1;
        for (int i = 0; i < 8; i++) wr(34'(i), 1'b1);
        check("fill_count", 64'(o_count), 64'd8);
        check("fill_full", 64'(o_full), 64'd1);
        check("fill_no_stb", 64'(o_rd_stb), 64'd0);
        check("fill_no_ovf", 64'(o_overflow), 64'd0);

        // Test: overflow on full FIFO, word never emerges
        wr(34'h3_00000009, 1'b0);
        check("ovf_set", 64'(o_overflow), 64'd1);
        check("ovf_count", 64'(o_count), 64'd8);

        // Test: release busy, 8 words at 2-cycle spacing
        have_last = 1'b0;
        spacing_en = 1'b1;
        busy_manual = 1'b0;
        wait_drain("drain8_timeout", 40);
        spacing_en = 1'b0;
        check("drain8_empty", 64'(o_empty), 64'd1);
        check("ovf_sticky", 64'(o_overflow), 64'd1);

        do_reset();
        check("ovf_cleared", 64'(o_overflow), 64'd0);

        // Test: coder busy model with 3-cycle-spaced writes
        model_en = 1'b1;
        peak = 0;
        for (int i = 0; i < 12; i++) begin
            wr(34'h1_A0000000 | 34'(i), 1'b1);
            @(negedge i_clk);
            @(negedge i_clk);
        end
        wait_drain("model_timeout", 200);
        check("model_no_ovf", 64'(o_overflow), 64'd0);
        check("model_peak_ok", 64'(peak <= 8), 64'd1);
        check("model_empty", 64'(o_empty), 64'd1);
        model_en = 1'b0;
        @(negedge i_clk);

        // Test: write and pop on the same edge at count 3
        busy_manual = 1'b1;
        for (int i = 0; i < 3; i++) wr(34'h0_5000_0000 | 34'(i), 1'b1);
        check("wp_pre_count", 64'(o_count), 64'd3);
        busy_manual = 1'b0;
        wr(34'h0_5000_0003, 1'b1);
        check("wp_count", 64'(o_count), 64'd3);
        check("wp_stb", 64'(o_rd_stb), 64'd1);
        wait_drain("wp_timeout", 20);

        // Test: reset mid-drain
        busy_manual = 1'b1;
        for (int i = 0; i < 5; i++) wr(34'h2_7000_0000 | 34'(i), 1'b1);
        busy_manual = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        do_reset();
        check("mid_rst_count", 64'(o_count), 64'd0);
        check("mid_rst_empty", 64'(o_empty), 64'd1);
        check("mid_rst_stb", 64'(o_rd_stb), 64'd0);
        check("mid_rst_ovf", 64'(o_overflow), 64'd0);
        repeat (3) @(negedge i_clk);
        check("mid_rst_no_stray", 64'(o_rd_stb), 64'd0);
        wr(34'h1_CAFEF00D, 1'b1);
        wait_drain("post_rst_timeout", 10);
        check("post_rst_empty", 64'(o_empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
